// File: rtl/packet_gen_pkg.sv
// packet_gen_pkg: shared states, lane width and beat/keep helpers for packet_gen
package packet_gen_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  localparam int LANE_W = 64;
  function automatic logic [15:0] beat_count(input logic [15:0] len, input int bpb);
    return 16'((int'(len) + bpb - 1) / bpb);
  endfunction
  function automatic logic keep_bit(input logic [15:0] rem, input int k);
    return rem == 16'd0 || k < int'(rem);
  endfunction
endpackage

// File: rtl/packet_gen_if.sv
// packet_gen_if: AXI-Stream transmit bundle with master/slave views
interface packet_gen_if #(parameter int DW = 512);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [1:0]      tuser;
  logic            tlast;
  logic            tvalid;
  logic            tready;
  modport master(output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave(input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/packet_gen_beat.sv
// packet_gen_beat: builds one beat's tdata/tkeep/tlast from packet, beat, beat count and remainder
module packet_gen_beat import packet_gen_pkg::*; #(parameter int DW = 512) (
  input  logic [31:0]     p,
  input  logic [15:0]     b,
  input  logic [15:0]     n,
  input  logic [15:0]     r,
  output logic [DW-1:0]   tdata,
  output logic [DW/8-1:0] tkeep,
  output logic            tlast
);
  localparam int KW = DW / 8;
  logic [DW-1:0] w_raw;
  assign tlast = b == n - 16'd1;
  for (genvar j = 0; j < DW / LANE_W; j++) begin : g_lane
    assign w_raw[j*LANE_W +: LANE_W] = {p, b, 16'(j)};
  end
  for (genvar k = 0; k < KW; k++) begin : g_byte
    assign tkeep[k] = tlast ? keep_bit(r, k) : 1'b1;
    assign tdata[k*8 +: 8] = tkeep[k] ? w_raw[k*8 +: 8] : 8'd0;
  end
endmodule

// File: rtl/packet_gen.sv
// packet_gen: deterministic AXI-Stream packet source for the 100GbE transmit path
module packet_gen import packet_gen_pkg::*; #(parameter int DW = 512) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] pkt_len,
  input  logic [31:0] pkt_count,
  input  logic [7:0]  gap_cycles,
  output logic        busy,
  output logic [31:0] packets_sent,
  packet_gen_if.master axis_tx
);
  localparam int KW = DW / 8;
  state_t          r_state, w_state;
  logic [15:0]     r_n, w_n, r_r, w_r, r_b, w_b;
  logic [31:0]     r_p, w_p, r_cnt, w_cnt, r_sent, w_sent;
  logic [7:0]      r_gap, w_gap, r_gcnt, w_gcnt;
  logic            r_stop, w_stop, r_busy, w_busy, r_valid, w_valid, r_tlast;
  logic            w_fire, w_end, w_tlast;
  logic [DW-1:0]   r_tdata, w_tdata;
  logic [KW-1:0]   r_tkeep, w_tkeep;
  packet_gen_beat #(.DW(DW)) u_beat (
    .p(w_p), .b(w_b), .n(w_n), .r(w_r),
    .tdata(w_tdata), .tkeep(w_tkeep), .tlast(w_tlast)
  );
  always_comb begin
    w_state = r_state;
    w_n = r_n;
    w_r = r_r;
    w_b = r_b;
    w_p = r_p;
    w_cnt = r_cnt;
    w_sent = r_sent;
    w_gap = r_gap;
    w_gcnt = r_gcnt;
    w_stop = r_stop | stop;
    w_busy = r_busy;
    w_valid = r_valid;
    w_fire = r_valid & axis_tx.tready;
    w_end = w_fire && r_b == r_n - 16'd1;
    case (r_state)
      IDLE: begin
        w_stop = 1'b0;
        if (start && pkt_len != 16'd0) begin
          w_state = SEND;
          w_n = beat_count(pkt_len, KW);
          w_r = 16'(int'(pkt_len) % KW);
          w_cnt = pkt_count;
          w_gap = gap_cycles;
          w_sent = '0;
          w_p = '0;
          w_b = '0;
          w_busy = 1'b1;
          w_valid = 1'b1;
        end
      end
      SEND: begin
        if (w_end) begin
          w_sent = r_sent + 32'(r_sent != '1);
          w_p = r_p + 32'd1;
          w_b = '0;
          w_stop = 1'b0;
          if ((r_cnt != '0 && w_sent == r_cnt) || r_stop || stop) begin
            w_state = IDLE;
            w_busy = 1'b0;
            w_valid = 1'b0;
          end else if (r_gap != '0) begin
            w_state = GAP;
            w_gcnt = r_gap;
            w_valid = 1'b0;
          end
        end else if (w_fire) begin
          w_b = r_b + 16'd1;
        end
      end
      GAP: begin
        if (stop) begin
          w_state = IDLE;
          w_busy = 1'b0;
        end else if (r_gcnt == 8'd1) begin
          w_state = SEND;
          w_valid = 1'b1;
        end else begin
          w_gcnt = r_gcnt - 8'd1;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_n <= '0;
      r_r <= '0;
      r_b <= '0;
      r_p <= '0;
      r_cnt <= '0;
      r_sent <= '0;
      r_gap <= '0;
      r_gcnt <= '0;
      r_stop <= 1'b0;
      r_busy <= 1'b0;
      r_valid <= 1'b0;
      r_tlast <= 1'b0;
      r_tdata <= '0;
      r_tkeep <= '0;
    end else begin
      r_state <= w_state;
      r_n <= w_n;
      r_r <= w_r;
      r_b <= w_b;
      r_p <= w_p;
      r_cnt <= w_cnt;
      r_sent <= w_sent;
      r_gap <= w_gap;
      r_gcnt <= w_gcnt;
      r_stop <= w_stop;
      r_busy <= w_busy;
      r_valid <= w_valid;
      r_tlast <= w_valid ? w_tlast : 1'b0;
      r_tdata <= w_valid ? w_tdata : '0;
      r_tkeep <= w_valid ? w_tkeep : '0;
    end
  end
  assign busy = r_busy;
  assign packets_sent = r_sent;
  assign axis_tx.tdata = r_tdata;
  assign axis_tx.tkeep = r_tkeep;
  assign axis_tx.tlast = r_tlast;
  assign axis_tx.tvalid = r_valid;
  assign axis_tx.tuser = 2'b00;
endmodule
